// File: rtl/mult_seq_shift_add_if.sv
// Operand/product handshake bundle for mult_seq_shift_add.
// master drives operands and out_ready; slave is the multiplier.
interface mult_seq_shift_add_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mult_seq_shift_add.sv
// Sequential unsigned shift-and-add multiplier, W cycles per product.
// Optional MULT_SEQ_ZERO_SKIP_EN: zero operand goes straight to HOLD.
module mult_seq_shift_add #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_seq_shift_add_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]     r_state;
    logic [W-1:0]   r_m;
    logic [2*W-1:0] r_p;
    logic [2*W-1:0] r_product;
    logic [CW-1:0]  r_cnt;

    logic [W-1:0]   w_hi;
    logic [W-1:0]   w_addend;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_p_nxt;
    logic           w_last;

    // Adder operands: upper partial product plus M when the LSB is set.
    assign w_hi     = r_p[2*W-1:W];
    assign w_addend = r_p[0] ? r_m : '0;
    assign w_sum    = {1'b0, w_hi} + {1'b0, w_addend};
    assign w_p_nxt  = {w_sum, r_p[W-1:1]};
    assign w_last   = (r_cnt == CW'(W - 1));

`ifdef MULT_SEQ_ZERO_SKIP_EN
    logic w_zero;
    assign w_zero = (bus.a == '0) || (bus.b == '0);
`endif

    // Handshake flags come from state alone.
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_CALC);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.product   = r_product;

    // Control FSM and shift-add datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_p       <= '0;
            r_product <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_m   <= bus.a;
                        r_cnt <= '0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                        if (w_zero) begin
                            r_p       <= '0;
                            r_product <= '0;
                            r_state   <= S_HOLD;
                        end else begin
                            r_p     <= {{W{1'b0}}, bus.b};
                            r_state <= S_CALC;
                        end
`else
                        r_p     <= {{W{1'b0}}, bus.b};
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_product <= w_p_nxt;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Directed bench for mult_seq_shift_add at W=4.
// Checks products, latency, busy width, backpressure and reset abort.
module tb_mult_seq_shift_add;
    localparam int W = 4;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    // zero operand: HOLD entered on the accept edge itself
    localparam int ZLAT  = 0;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = W;
    localparam int ZBUSY = W;
`endif

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    logic [2*W-1:0] last_prod;

    mult_seq_shift_add_if #(.W(W)) bus ();

    mult_seq_shift_add #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia,
                          input logic [W-1:0] ib,
                          input int exp_lat,
                          input int exp_busy,
                          input string tag);
        int k;
        int n;
        int nb;
        logic [2*W-1:0] exp_p;
        exp_p = (2*W)'(ia) * (2*W)'(ib);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a = ia;
        bus.b = ib;
        @(negedge clk);
        k = cyc;
        bus.in_valid = 1'b0;
        if (!bus.out_valid)
            chk({tag, "_old"}, 32'(bus.product), 32'(last_prod));
        nb = 0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            if (bus.busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_ov"}, 32'(bus.out_valid), 1);
        chk({tag, "_lat"}, 32'(cyc - k), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(nb), 32'(exp_busy));
        chk({tag, "_prod"}, 32'(bus.product), 32'(exp_p));
        last_prod = exp_p;
        if (bus.out_ready) begin
            @(negedge clk);
            chk({tag, "_done"}, 32'(bus.in_ready), 1);
            chk({tag, "_ovlo"}, 32'(bus.out_valid), 0);
            chk({tag, "_keep"}, 32'(bus.product), 32'(exp_p));
        end
    endtask

    initial begin
        int n;
        int k;
        int prev_k;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_cmp = 0;
        n_err = 0;
        last_prod = '0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        #120;
        chk("rst_rdy", 32'(bus.in_ready), 1);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_prod", 32'(bus.product), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd7, 4'd5, W, W, "m7x5");
        run_op(4'd15, 4'd15, W, W, "m15x15");
        run_op(4'd8, 4'd8, W, W, "m8x8");

        // backpressure: hold 13*11 while pulsing a new pair
        bus.out_ready = 1'b0;
        run_op(4'd13, 4'd11, W, W, "bp");
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                bus.in_valid = 1'b1;
                bus.a = 4'd1;
                bus.b = 4'd1;
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("bp_ov", 32'(bus.out_valid), 1);
            chk("bp_prod", 32'(bus.product), 32'h8F);
            chk("bp_nrdy", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel", 32'(bus.in_ready), 1);
        chk("bp_prod2", 32'(bus.product), 32'h8F);
        run_op(4'd1, 4'd1, W, W, "m1x1");

        run_op(4'd0, 4'd13, ZLAT, ZBUSY, "zero");

        // reset two cycles into a 9*6 calculation
        run_op(4'd2, 4'd3, W, W, "m2x3");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 4'd9;
        bus.b = 4'd6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #10;
        chk("mid_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_ov", 32'(bus.out_valid), 0);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_rdy", 32'(bus.in_ready), 1);
        chk("ar_prod", 32'(bus.product), 0);
        last_prod = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd3, 4'd4, W, W, "m3x4");

        // back-to-back, in_valid and out_ready held high
        bus.out_ready = 1'b1;
        bus.a = 4'($urandom_range(1, 15));
        bus.b = 4'($urandom_range(1, 15));
        bus.in_valid = 1'b1;
        prev_k = -1;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_rdy", 32'(bus.in_ready), 1);
            ra = bus.a;
            rb = bus.b;
            @(negedge clk);
            k = cyc;
            if (prev_k >= 0)
                chk("b2b_gap", 32'(k - prev_k), 32'(W + 2));
            prev_k = k;
            bus.a = 4'($urandom_range(1, 15));
            bus.b = 4'($urandom_range(1, 15));
            n = 0;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ov", 32'(bus.out_valid), 1);
            chk("b2b_prod", 32'(bus.product),
                32'((2*W)'(ra) * (2*W)'(rb)));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
